// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer: states, opcodes,
// datapath mux selects and the packed control word driven onto the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ASEL_A      = 2'd0;
  localparam logic [1:0] ASEL_PC     = 2'd1;
  localparam logic [1:0] ASEL_OLD_PC = 2'd2;

  localparam logic [1:0] BSEL_B    = 2'd0;
  localparam logic [1:0] BSEL_FOUR = 2'd1;
  localparam logic [1:0] BSEL_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // old_pc_we is not carried here: it is by definition identical to ir_we.
  typedef struct packed {
    logic       pc_we;
    logic       pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       ab_we;
    logic       aluout_we;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       mdr_we;
    logic       instr_done;
  } ctrl_t;

  function automatic state_t dispatch(input logic [6:0] opcode);
    state_t nxt;
    case (opcode)
      OP_ADD:       nxt = S_EXE_R;
      OP_ADDI:      nxt = S_EXE_I;
      OP_LW, OP_SW: nxt = S_ADDR;
      OP_BEQ:       nxt = S_BRANCH;
      OP_JAL:       nxt = S_JAL;
      default:      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from sequencer state plus same-cycle qualifiers
// (cpu_en, mem_ready, alu_zero) to the datapath control word.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   cpu_en,
  input  logic   mem_ready,
  input  logic   alu_zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        if (cpu_en) begin
          ctrl.mem_re    = 1'b1;
          ctrl.iord      = 1'b0;
          ctrl.alu_a_sel = ASEL_PC;
          ctrl.alu_b_sel = BSEL_FOUR;
          ctrl.alu_op    = ALU_ADD;
          if (mem_ready) begin
            ctrl.ir_we  = 1'b1;
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PCSRC_ALU;
          end
        end
      end
      // old_pc + imm lands in ALUOut now so BRANCH/JAL can use it as target.
      S_DECODE: begin
        ctrl.ab_we     = 1'b1;
        ctrl.aluout_we = 1'b1;
        ctrl.alu_a_sel = ASEL_OLD_PC;
        ctrl.alu_b_sel = BSEL_IMM;
      end
      S_EXE_R: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_a_sel = ASEL_A;
        ctrl.alu_b_sel = BSEL_B;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXE_I, S_ADDR: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_a_sel = ASEL_A;
        ctrl.alu_b_sel = BSEL_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_re = 1'b1;
        ctrl.iord   = 1'b1;
        ctrl.mdr_we = mem_ready;
      end
      S_MEM_WR: begin
        ctrl.mem_we     = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_WB_ALU: begin
        ctrl.reg_we     = 1'b1;
        ctrl.wb_sel     = WB_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.wb_sel     = WB_MDR;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_a_sel  = ASEL_A;
        ctrl.alu_b_sel  = BSEL_B;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.pc_we      = alu_zero;
        ctrl.instr_done = 1'b1;
      end
      // PC was already advanced to PC+4 in FETCH, so it is the link value.
      S_JAL: begin
        ctrl.reg_we     = 1'b1;
        ctrl.wb_sel     = WB_PC;
        ctrl.pc_we      = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for add/addi/lw/sw/beq/jal: state register,
// next-state logic, sticky trap flag, and reset-gated control outputs.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_en,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       pc_src,
  output logic       old_pc_we,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ab_we,
  output logic       aluout_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       mdr_we,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t state_nxt;
  logic   trap_q;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (cpu_en && mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = dispatch(opcode);
      S_EXE_R:  state_nxt = S_WB_ALU;
      S_EXE_I:  state_nxt = S_WB_ALU;
      S_ADDR:   state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_nxt = S_FETCH;
      S_WB_ALU: state_nxt = S_FETCH;
      S_WB_MEM: state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JAL:    state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_FETCH;
      trap_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) trap_q <= 1'b1;
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .cpu_en    (cpu_en),
    .mem_ready (mem_ready),
    .alu_zero  (alu_zero),
    .ctrl      (ctrl_raw)
  );

  // Holding rstn low silences the datapath immediately, even mid-handshake.
  assign ctrl = rstn ? ctrl_raw : '0;

  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign ir_we      = ctrl.ir_we;
  assign old_pc_we  = ctrl.ir_we;
  assign iord       = ctrl.iord;
  assign mem_re     = ctrl.mem_re;
  assign mem_we     = ctrl.mem_we;
  assign ab_we      = ctrl.ab_we;
  assign aluout_we  = ctrl.aluout_we;
  assign alu_a_sel  = ctrl.alu_a_sel;
  assign alu_b_sel  = ctrl.alu_b_sel;
  assign alu_op     = ctrl.alu_op;
  assign reg_we     = ctrl.reg_we;
  assign wb_sel     = ctrl.wb_sel;
  assign mdr_we     = ctrl.mdr_we;
  assign instr_done = ctrl.instr_done;
  assign trap       = rstn & trap_q;
  assign state_dbg  = rstn ? state : 4'd0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Cycle-by-cycle bench for mc_control_fsm: each scenario lists the expected
// state sequence; a reference table turns it into the expected control word.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rstn, cpu_en, alu_zero, mem_ready;
  logic [6:0] opcode;
  logic       pc_we, pc_src, old_pc_we, ir_we, iord, mem_re, mem_we, ab_we, aluout_we;
  logic [1:0] alu_a_sel, alu_b_sel, wb_sel;
  logic       alu_op, reg_we, mdr_we, instr_done, trap;
  logic [3:0] state_dbg;

  localparam logic [3:0] F = 4'd0, D = 4'd1, ER = 4'd2, EI = 4'd3, AD = 4'd4, MR = 4'd5,
                         MW = 4'd6, WA = 4'd7, WM = 4'd8, BR = 4'd9, JL = 4'd10, TR = 4'd11;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] sb_q[$];
  logic [23:0] obs;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rstn(rstn), .cpu_en(cpu_en), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .old_pc_we(old_pc_we),
    .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we), .ab_we(ab_we),
    .aluout_we(aluout_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .mdr_we(mdr_we), .instr_done(instr_done),
    .trap(trap), .state_dbg(state_dbg)
  );

  assign obs = {pc_we, pc_src, old_pc_we, ir_we, iord, mem_re, mem_we, ab_we, aluout_we,
                alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, mdr_we, instr_done, trap, state_dbg};

  function automatic logic [23:0] exp_word(input logic [3:0] st, input logic en, input logic rdy,
                                           input logic z, input logic rn, input logic tr);
    logic pw, ps, opw, iw, io, re, we, ab, ao, op, rw, mw, dn;
    logic [1:0] as, bs, wb;
    {pw, ps, opw, iw, io, re, we, ab, ao, op, rw, mw, dn} = '0;
    {as, bs, wb} = '0;
    if (!rn) return 24'd0;
    case (st)
      F:  if (en) begin re = 1; as = 1; bs = 1; if (rdy) begin iw = 1; opw = 1; pw = 1; end end
      D:  begin ab = 1; ao = 1; as = 2; bs = 2; end
      ER: begin ao = 1; end
      EI, AD: begin ao = 1; bs = 2; end
      MR: begin re = 1; io = 1; mw = rdy; end
      MW: begin we = 1; io = 1; dn = rdy; end
      WA: begin rw = 1; dn = 1; end
      WM: begin rw = 1; wb = 1; dn = 1; end
      BR: begin op = 1; ps = 1; pw = z; dn = 1; end
      JL: begin rw = 1; wb = 2; pw = 1; ps = 1; dn = 1; end
      default: ;
    endcase
    return {pw, ps, opw, iw, io, re, we, ab, ao, as, bs, op, rw, wb, mw, dn, tr, st};
  endfunction

  task automatic cyc(input string name, input logic [3:0] st, input logic en, input logic rdy,
                     input logic z, input logic rn, input logic tr);
    logic [23:0] want;
    cpu_en = en; mem_ready = rdy; alu_zero = z; rstn = rn;
    sb_q.push_back(exp_word(st, en, rdy, z, rn, tr));
    @(negedge clk);
    want = sb_q.pop_front();
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h want %h (state_dbg got %0d want %0d)",
               name, vectors, obs, want, state_dbg, want[3:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cyc("reset_force0", F, 1, 1, 0, 0, 0);
    cyc("reset_force0b", F, 1, 1, 0, 0, 0);
    cyc("reset_idle", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_add();
    opcode = 7'b0110011;
    cyc("add_fetch", F, 1, 1, 0, 1, 0);
    cyc("add_decode", D, 1, 0, 0, 1, 0);
    cyc("add_exe", ER, 0, 1, 0, 1, 0);
    cyc("add_wb", WA, 0, 0, 0, 1, 0);
    cyc("add_idle", F, 0, 0, 0, 1, 0);
  endtask

  task automatic test_lw_wait();
    opcode = 7'b0000011;
    cyc("lw_fetch", F, 1, 1, 0, 1, 0);
    cyc("lw_decode", D, 0, 1, 0, 1, 0);
    cyc("lw_addr", AD, 0, 1, 0, 1, 0);
    cyc("lw_wait1", MR, 0, 0, 0, 1, 0);
    cyc("lw_wait2", MR, 0, 0, 0, 1, 0);
    cyc("lw_rdy", MR, 0, 1, 0, 1, 0);
    cyc("lw_wb", WM, 0, 1, 0, 1, 0);
    cyc("lw_idle", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_sw_fetch_wait();
    opcode = 7'b0100011;
    cyc("sw_fetch_wait", F, 1, 0, 0, 1, 0);
    cyc("sw_fetch", F, 1, 1, 0, 1, 0);
    cyc("sw_decode", D, 0, 0, 0, 1, 0);
    cyc("sw_addr", AD, 0, 0, 0, 1, 0);
    cyc("sw_memwr", MW, 0, 1, 0, 1, 0);
    cyc("sw_idle", F, 0, 0, 0, 1, 0);
  endtask

  task automatic test_beq();
    opcode = 7'b1100011;
    cyc("beq_t_fetch", F, 1, 1, 0, 1, 0);
    cyc("beq_t_decode", D, 0, 1, 1, 1, 0);
    cyc("beq_taken", BR, 0, 1, 1, 1, 0);
    cyc("beq_nt_fetch", F, 1, 1, 1, 1, 0);
    cyc("beq_nt_decode", D, 0, 1, 0, 1, 0);
    cyc("beq_not_taken", BR, 0, 1, 0, 1, 0);
    cyc("beq_idle", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_jal();
    opcode = 7'b1101111;
    cyc("jal_fetch", F, 1, 1, 0, 1, 0);
    cyc("jal_decode", D, 0, 1, 0, 1, 0);
    cyc("jal_exec", JL, 0, 1, 0, 1, 0);
    cyc("jal_idle", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_pause_step();
    opcode = 7'b0010011;
    for (int i = 0; i < 5; i++) cyc("pause_hold", F, 0, 1, 0, 1, 0);
    cyc("step_fetch", F, 1, 1, 0, 1, 0);
    cyc("step_decode", D, 0, 1, 0, 1, 0);
    cyc("step_exe", EI, 0, 1, 0, 1, 0);
    cyc("step_wb", WA, 0, 1, 0, 1, 0);
    cyc("step_hold1", F, 0, 1, 0, 1, 0);
    cyc("step_hold2", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    opcode = 7'b0110011;
    cyc("b2b_add_fetch", F, 1, 1, 0, 1, 0);
    cyc("b2b_add_decode", D, 1, 1, 0, 1, 0);
    cyc("b2b_add_exe", ER, 1, 1, 0, 1, 0);
    cyc("b2b_add_wb", WA, 1, 1, 0, 1, 0);
    opcode = 7'b1101111;
    cyc("b2b_jal_fetch", F, 1, 1, 0, 1, 0);
    cyc("b2b_jal_decode", D, 1, 1, 0, 1, 0);
    cyc("b2b_jal_exec", JL, 1, 1, 0, 1, 0);
    cyc("b2b_idle", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_trap();
    opcode = 7'b0000000;
    cyc("trap_fetch", F, 1, 1, 0, 1, 0);
    cyc("trap_decode", D, 1, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc("trap_sticky", TR, 1, 1, 0, 1, 1);
    cyc("trap_reset", TR, 1, 1, 0, 0, 0);
    cyc("trap_cleared", F, 0, 1, 0, 1, 0);
  endtask

  task automatic test_reset_mid_memwr();
    opcode = 7'b0100011;
    cyc("rmw_fetch", F, 1, 1, 0, 1, 0);
    cyc("rmw_decode", D, 0, 1, 0, 1, 0);
    cyc("rmw_addr", AD, 0, 1, 0, 1, 0);
    cyc("rmw_wait", MW, 0, 0, 0, 1, 0);
    cyc("rmw_reset", MW, 0, 0, 0, 0, 0);
    cyc("rmw_after", F, 0, 1, 0, 1, 0);
  endtask

  initial begin
    rstn = 1'b0; cpu_en = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_fetch_wait();
    test_beq();
    test_jal();
    test_pause_step();
    test_back_to_back();
    test_trap();
    test_reset_mid_memwr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
